// File: rtl/reg_snapshot_pkg.sv
// Shared types and constants for the register snapshot scanner.
package reg_snapshot_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 13;
  localparam int DEF_CNT_W    = 16;
  localparam int ADDR_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_READ  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  // Scanner is armed or actively emitting words.
  function automatic logic is_busy_state(input scan_state_e st);
    return (st == ST_COUNT) || (st == ST_READ) || (st == ST_HOLD);
  endfunction

  // Register-file writes must be stalled while words are being read out.
  function automatic logic is_freeze_state(input scan_state_e st);
    return (st == ST_READ) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/reg_snapshot_scanner_counter.sv
// Delay counter: load latches the wait length (zero behaves as one) and
// clears the count; tc_o flags the final wait cycle. Counting stops at the
// terminal value, so the count can never wrap.
module snap_cycle_counter
  import reg_snapshot_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] end_count_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] limit_r;
  logic             tc_s;

  assign tc_s = (cnt_r == (limit_r - ONE_C));
  assign tc_o = tc_s;

  // Latch the wait length on load, then advance once per enabled cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r   <= ZERO_C;
      limit_r <= ONE_C;
    end else if (load_i) begin
      cnt_r   <= ZERO_C;
      limit_r <= (end_count_i == ZERO_C) ? ONE_C : end_count_i;
    end else if (en_i && !tc_s) begin
      cnt_r   <= cnt_r + ONE_C;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/reg_snapshot_scanner.sv
// Register snapshot scanner: waits a programmed number of cycles, then
// freezes the register file and streams r0..NUM_REGS-1 out over a
// valid/ready port, one word per handshake.
module reg_snapshot_scanner
  import reg_snapshot_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  end_count_i,
  output logic [4:0]        rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              freeze_o,
  output logic              snap_valid_o,
  input  logic              snap_ready_i,
  output logic [4:0]        snap_idx_o,
  output logic [DATA_W-1:0] snap_data_o,
  output logic              snap_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX_C = ADDR_W'(NUM_REGS - 1);

  scan_state_e       state_r;
  scan_state_e       state_nxt_s;
  logic              load_s;
  logic              tc_s;
  logic              handshake_s;
  logic              at_last_s;
  logic [ADDR_W-1:0] idx_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              last_r;
  logic              busy_r;
  logic              freeze_r;
  logic              done_r;

  assign handshake_s = valid_r && snap_ready_i;
  assign at_last_s   = (idx_r == LAST_IDX_C);

  snap_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_s),
    .en_i        (state_r == ST_COUNT),
    .end_count_i (end_count_i),
    .tc_o        (tc_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start_i only matters when idle or finished.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          load_s      = 1'b1;
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_COUNT: begin
        if (tc_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (handshake_s) begin
          state_nxt_s = at_last_s ? ST_DONE : ST_READ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Index, captured word and status flags, all registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_r    <= {ADDR_W{1'b0}};
      data_r   <= {DATA_W{1'b0}};
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
      freeze_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r   <= is_busy_state(state_nxt_s);
      freeze_r <= is_freeze_state(state_nxt_s);
      done_r   <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            idx_r <= {ADDR_W{1'b0}};
          end
        end
        ST_READ: begin
          data_r  <= rf_data_i;
          valid_r <= 1'b1;
          last_r  <= at_last_s;
        end
        ST_HOLD: begin
          if (handshake_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            if (!at_last_s) begin
              idx_r <= idx_r + 5'd1;
            end
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign rf_addr_o    = idx_r;
  assign snap_idx_o   = idx_r;
  assign snap_data_o  = data_r;
  assign snap_valid_o = valid_r;
  assign snap_last_o  = last_r;
  assign busy_o       = busy_r;
  assign freeze_o     = freeze_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_reg_snapshot_scanner.sv
// Bench for reg_snapshot_scanner: randomized register contents and ready
// patterns checked against a cycle timeline derived from the scan rules.
module tb_reg_snapshot_scanner;

  localparam int DATA_W = 32;
  localparam int NREGS  = 13;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [CNT_W-1:0]  end_count_i;
  logic [4:0]        rf_addr_o;
  logic [DATA_W-1:0] rf_data_i;
  logic              freeze_o;
  logic              snap_valid_o;
  logic              snap_ready_i;
  logic [4:0]        snap_idx_o;
  logic [DATA_W-1:0] snap_data_o;
  logic              snap_last_o;
  logic              busy_o;
  logic              done_o;

  logic [DATA_W-1:0] rf_mem [32];
  int vectors = 0;
  int miscompares = 0;

  assign rf_data_i = rf_mem[rf_addr_o];

  always #5 clk_i = ~clk_i;

  reg_snapshot_scanner #(.DATA_W(DATA_W), .NUM_REGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .end_count_i  (end_count_i),
    .rf_addr_o    (rf_addr_o),
    .rf_data_i    (rf_data_i),
    .freeze_o     (freeze_o),
    .snap_valid_o (snap_valid_o),
    .snap_ready_i (snap_ready_i),
    .snap_idx_o   (snap_idx_o),
    .snap_data_o  (snap_data_o),
    .snap_last_o  (snap_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"},  64'(snap_valid_o), 64'd0);
    chk({tag, "_busy"},   64'(busy_o),       64'd0);
    chk({tag, "_freeze"}, 64'(freeze_o),     64'd0);
    chk({tag, "_done"},   64'(done_o),       64'd0);
    chk({tag, "_last"},   64'(snap_last_o),  64'd0);
    chk({tag, "_addr"},   64'(rf_addr_o),    64'd0);
    chk({tag, "_idx"},    64'(snap_idx_o),   64'd0);
    chk({tag, "_data"},   64'(snap_data_o),  64'd0);
  endtask

  // mode 0: ready always 1; mode 1: random ready and stray start pulses in HOLD;
  // mode 2: ready low for 5 cycles while word 3 is offered.
  // abort_idx >= 0 pulls reset while that word is held.
  // poke pulses start_i during the wait phase with a different end count.
  task automatic run_scan(input int ec, input int mode, input int abort_idx, input bit poke);
    int  eff, phase, k, waited, guard, low_cnt;
    bit  finished, rdy;
    eff = (ec == 0) ? 1 : ec;
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
    @(negedge clk_i);
    start_i     = 1'b1;
    end_count_i = CNT_W'(ec);
    phase = 0; k = 0; waited = 0; guard = 0; low_cnt = 0; finished = 1'b0;
    while (!finished && guard < 3000) begin
      @(negedge clk_i);
      guard++;
      start_i      = 1'b0;
      end_count_i  = CNT_W'($urandom);
      snap_ready_i = 1'($urandom_range(0, 1));
      case (phase)
        0: begin
          chk("wait_busy",   64'(busy_o),       64'd1);
          chk("wait_freeze", 64'(freeze_o),     64'd0);
          chk("wait_valid",  64'(snap_valid_o), 64'd0);
          chk("wait_done",   64'(done_o),       64'd0);
          waited++;
          if (poke && waited == 2) begin
            start_i     = 1'b1;
            end_count_i = CNT_W'(2);
          end
          if (waited == eff) phase = 1;
        end
        1: begin
          chk("read_busy",   64'(busy_o),       64'd1);
          chk("read_freeze", 64'(freeze_o),     64'd1);
          chk("read_valid",  64'(snap_valid_o), 64'd0);
          chk("read_addr",   64'(rf_addr_o),    64'(k));
          phase = 2;
        end
        2: begin
          chk("hold_valid",  64'(snap_valid_o), 64'd1);
          chk("hold_busy",   64'(busy_o),       64'd1);
          chk("hold_freeze", 64'(freeze_o),     64'd1);
          chk("hold_idx",    64'(snap_idx_o),   64'(k));
          chk("hold_addr",   64'(rf_addr_o),    64'(k));
          chk("hold_data",   64'(snap_data_o),  64'(rf_mem[k]));
          chk("hold_last",   64'(snap_last_o),  64'(k == NREGS - 1));
          if (k == abort_idx) begin
            rst_i = 1'b0;
            #1;
            chk_idle_outputs("abort");
            @(negedge clk_i);
            rst_i = 1'b1;
            for (int c = 0; c < 20; c++) begin
              @(negedge clk_i);
              snap_ready_i = 1'($urandom_range(0, 1));
              chk("post_abort_valid", 64'(snap_valid_o), 64'd0);
              chk("post_abort_busy",  64'(busy_o),       64'd0);
              chk("post_abort_done",  64'(done_o),       64'd0);
            end
            finished = 1'b1;
          end else begin
            if (mode == 0) begin
              rdy = 1'b1;
            end else if (mode == 1) begin
              rdy = 1'($urandom_range(0, 1));
              start_i = 1'($urandom_range(0, 1));
            end else if (k == 3 && low_cnt < 5) begin
              rdy = 1'b0;
              low_cnt++;
            end else begin
              rdy = 1'b1;
            end
            snap_ready_i = rdy;
            if (rdy) begin
              if (k == NREGS - 1) phase = 3;
              else begin
                k++;
                phase = 1;
              end
            end
          end
        end
        default: begin
          chk("done_done",   64'(done_o),       64'd1);
          chk("done_busy",   64'(busy_o),       64'd0);
          chk("done_freeze", 64'(freeze_o),     64'd0);
          chk("done_valid",  64'(snap_valid_o), 64'd0);
          finished = 1'b1;
        end
      endcase
    end
    if (!finished) chk("scan_timeout", 64'd0, 64'd1);
    if (mode == 2) chk("ready_low_cycles", 64'(low_cnt), 64'd5);
  endtask

  initial begin
    rst_i        = 1'b0;
    start_i      = 1'b0;
    end_count_i  = CNT_W'(0);
    snap_ready_i = 1'b0;
    for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_idle_outputs("post_reset");

    run_scan(25, 0, -1, 1'b0);   // full scan, ready tied high
    run_scan(0,  0, -1, 1'b0);   // zero wait acts as one
    run_scan(9,  2, -1, 1'b0);   // backpressure on word 3
    run_scan(6,  1, 7,  1'b0);   // reset while word 7 is held
    run_scan(10, 0, -1, 1'b1);   // start during wait is ignored
    run_scan(4,  0, -1, 1'b0);   // rearm from DONE with a 4-cycle wait
    for (int n = 0; n < 4; n++) begin
      run_scan(int'($urandom_range(0, 20)), 1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_snapshot_scanner.md
REG_SNAPSHOT_SCANNER -- requirements
Module: reg_snapshot_scanner

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 SHALL have parameter NUM_REGS, default 13, meaning registers scanned (r0..NUM_REGS-1), 1..32.
REQ-003 SHALL have parameter CNT_W, default 16, meaning cycle-counter width.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  arm request, sampled in IDLE or DONE.
REQ-007 SHALL have port end_count_i  input  CNT_W  cycles to wait before snapshot, sampled with start_i.
REQ-008 SHALL have port rf_addr_o  output  5  register-file read address.
REQ-009 SHALL have port rf_data_i  input  DATA_W  register-file read data, combinational from rf_addr_o.
REQ-010 SHALL have port freeze_o  output  1  request to stall register-file writes.
REQ-011 SHALL have port snap_valid_o  output  1  snapshot word valid.
REQ-012 SHALL have port snap_ready_i  input  1  consumer accepts word.
REQ-013 SHALL have port snap_idx_o  output  5  register index of current word.
REQ-014 SHALL have port snap_data_o  output  DATA_W  register value.
REQ-015 SHALL have port snap_last_o  output  1  current word is index NUM_REGS-1.
REQ-016 SHALL have ports busy_o and done_o, output, 1 each: armed/scanning, and scan complete.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT, READ, HOLD, DONE.
REQ-018 IDLE/DONE with start_i=1 SHALL latch end_count_i (0 treated as 1), clear counter and index, enter COUNT next cycle.
REQ-019 COUNT SHALL increment counter every cycle; on the cycle counter equals latched value minus 1 SHALL enter READ (exactly end-count cycles spent in COUNT).
REQ-020 READ SHALL drive rf_addr_o=index, register rf_data_i into snap_data_o, set snap_valid_o, enter HOLD; one cycle.
REQ-021 HOLD SHALL keep snap_valid_o, snap_data_o, snap_idx_o stable until snap_valid_o & snap_ready_i.
REQ-022 On handshake in HOLD: if index = NUM_REGS-1 SHALL clear valid and enter DONE, else increment index, clear valid, enter READ.
REQ-023 snap_ready_i asserted without snap_valid_o SHALL have no effect.
REQ-024 freeze_o SHALL be 1 exactly in READ and HOLD.
REQ-025 busy_o SHALL be 1 in COUNT, READ, HOLD; done_o SHALL be 1 only in DONE.
REQ-026 start_i during COUNT, READ, HOLD SHALL be ignored.
REQ-027 Counter SHALL saturate logic-free by construction (latched value ≤ 2^CNT_W-1); no wrap-around inside COUNT.
REQ-028 rf_addr_o SHALL equal index in all states.

Reset
REQ-029 rst_i low SHALL asynchronously force IDLE, counter 0, index 0, snap_data_o 0, all 1-bit outputs 0, rf_addr_o 0.
REQ-030 Reset asserted mid-scan SHALL abort; no word is emitted after reset release until a new start_i.
REQ-031 Reset release SHALL be synchronous-deasserted by the surrounding system; block takes no action on first edge other than IDLE evaluation.

Structure
REQ-032 Shared package reg_snapshot_pkg SHALL hold state enum, default NUM_REGS, DATA_W, CNT_W constants.
REQ-033 Cycle counter SHALL be sub-module snap_cycle_counter (load, enable, terminal-count output); FSM and output register in top.

Verification
REQ-034 start_i=1, end_count_i=25, ready tied 1 -> busy 25 cycles in COUNT, then 13 words idx 0..12 each two cycles apart, snap_last_o on idx 12, done_o after.
REQ-035 end_count_i=0 -> behaves as 1: READ entered one cycle after COUNT entry.
REQ-036 Ready low 5 cycles during idx 3 -> valid, idx 3, data held constant 5 cycles; freeze_o stays 1.
REQ-037 rst_i low during HOLD idx 7 -> immediate IDLE, valid 0, no further words until new start_i.
REQ-038 start_i pulsed during COUNT and again in DONE with end_count_i=4 -> first ignored, second rearms with 4-cycle wait.
